// File: rtl/aq_jpeg_pkg.sv
// Shared JPEG marker constants, writer state encoding and default Huffman ROM size.
package aq_jpeg_pkg;

    localparam int DHT_BYTES_DEF = 416;

    localparam logic [7:0] MK_PREFIX = 8'hFF;
    localparam logic [7:0] MK_SOI    = 8'hD8;
    localparam logic [7:0] MK_DQT    = 8'hDB;
    localparam logic [7:0] MK_SOF0   = 8'hC0;
    localparam logic [7:0] MK_DHT    = 8'hC4;
    localparam logic [7:0] MK_SOS    = 8'hDA;
    localparam logic [7:0] MK_EOI    = 8'hD9;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SOI,
        ST_DQT,
        ST_SOF,
        ST_DHT,
        ST_SOS,
        ST_SCAN,
        ST_STUFF,
        ST_EOI
    } state_t;

    // Header segments are emitted in a fixed order; anything after SOS is the scan.
    function automatic state_t next_segment(input state_t s);
        case (s)
            ST_SOI:  return ST_DQT;
            ST_DQT:  return ST_SOF;
            ST_SOF:  return ST_DHT;
            ST_DHT:  return ST_SOS;
            default: return ST_SCAN;
        endcase
    endfunction

endpackage

// File: rtl/aq_jpeg_hdr_field.sv
// Combinational header byte map: {state, byte index, frame params} -> fixed byte, ROM-slot flag, segment-last flag.
// Zero latency; no flow control of its own.
module aq_jpeg_hdr_field
    import aq_jpeg_pkg::*;
#(
    parameter int DHT_BYTES = DHT_BYTES_DEF
) (
    input  logic [3:0]  state,
    input  logic [9:0]  idx,
    input  logic        three,
    input  logic [15:0] width,
    input  logic [15:0] height,
    input  logic [7:0]  samp,
    output logic [7:0]  hdr_byte,
    output logic        rom_sel,
    output logic        seg_last
);

    localparam logic [15:0] DHT_LEN  = 16'(DHT_BYTES + 2);
    localparam logic [9:0]  DHT_LAST = 10'(DHT_BYTES + 3);

    state_t     st;
    logic [9:0] sos_pos;

    assign st = state_t'(state);
    // Grayscale SOS skips the Cb/Cr entries, so remap onto the 3-component layout.
    assign sos_pos = (!three && idx >= 10'd7) ? idx + 10'd4 : idx;

    always_comb begin
        hdr_byte = 8'h00;
        rom_sel  = 1'b0;
        seg_last = 1'b0;
        case (st)
            ST_SOI, ST_EOI: begin
                hdr_byte = (idx == 10'd0) ? MK_PREFIX : ((st == ST_SOI) ? MK_SOI : MK_EOI);
                seg_last = (idx == 10'd1);
            end
            ST_DQT: begin
                case (idx)
                    10'd0:   hdr_byte = MK_PREFIX;
                    10'd1:   hdr_byte = MK_DQT;
                    10'd2:   hdr_byte = 8'h00;
                    10'd3:   hdr_byte = three ? 8'd132 : 8'd67;
                    10'd4:   hdr_byte = 8'h00;
                    10'd69:  hdr_byte = 8'h01;
                    default: rom_sel  = 1'b1;
                endcase
                seg_last = (idx == (three ? 10'd133 : 10'd68));
            end
            ST_SOF: begin
                case (idx)
                    10'd0:   hdr_byte = MK_PREFIX;
                    10'd1:   hdr_byte = MK_SOF0;
                    10'd2:   hdr_byte = 8'h00;
                    10'd3:   hdr_byte = three ? 8'h11 : 8'h0B;
                    10'd4:   hdr_byte = 8'h08;
                    10'd5:   hdr_byte = height[15:8];
                    10'd6:   hdr_byte = height[7:0];
                    10'd7:   hdr_byte = width[15:8];
                    10'd8:   hdr_byte = width[7:0];
                    10'd9:   hdr_byte = three ? 8'h03 : 8'h01;
                    10'd10:  hdr_byte = 8'h01;
                    10'd11:  hdr_byte = samp;
                    10'd13:  hdr_byte = 8'h02;
                    10'd14:  hdr_byte = 8'h11;
                    10'd15:  hdr_byte = 8'h01;
                    10'd16:  hdr_byte = 8'h03;
                    10'd17:  hdr_byte = 8'h11;
                    10'd18:  hdr_byte = 8'h01;
                    default: hdr_byte = 8'h00;
                endcase
                seg_last = (idx == (three ? 10'd18 : 10'd12));
            end
            ST_DHT: begin
                case (idx)
                    10'd0:   hdr_byte = MK_PREFIX;
                    10'd1:   hdr_byte = MK_DHT;
                    10'd2:   hdr_byte = DHT_LEN[15:8];
                    10'd3:   hdr_byte = DHT_LEN[7:0];
                    default: rom_sel  = 1'b1;
                endcase
                seg_last = (idx == DHT_LAST);
            end
            ST_SOS: begin
                case (sos_pos)
                    10'd0:   hdr_byte = MK_PREFIX;
                    10'd1:   hdr_byte = MK_SOS;
                    10'd3:   hdr_byte = three ? 8'h0C : 8'h08;
                    10'd4:   hdr_byte = three ? 8'h03 : 8'h01;
                    10'd5:   hdr_byte = 8'h01;
                    10'd7:   hdr_byte = 8'h02;
                    10'd8:   hdr_byte = 8'h11;
                    10'd9:   hdr_byte = 8'h03;
                    10'd10:  hdr_byte = 8'h11;
                    10'd12:  hdr_byte = 8'h3F;
                    default: hdr_byte = 8'h00;
                endcase
                seg_last = (sos_pos == 10'd13);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/aq_jpeg_hdr_writer.sv
// JPEG stream writer: SOI/DQT/SOF0/DHT/SOS header, 0xFF-stuffed scan pass-through, EOI.
// One output register; ROM bytes take 2 cycles, others 1; every stage stalls while OutValid&!OutReady.
module aq_jpeg_hdr_writer
    import aq_jpeg_pkg::*;
#(
    parameter int DHT_BYTES = DHT_BYTES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic [15:0] Width,
    input  logic [15:0] Height,
    input  logic [2:0]  CompNum,
    input  logic [1:0]  SubSamplingW,
    input  logic [1:0]  SubSamplingH,
    output logic [6:0]  DqtAddr,
    input  logic [7:0]  DqtData,
    output logic [8:0]  DhtAddr,
    input  logic [7:0]  DhtData,
    input  logic        ScanValid,
    input  logic [7:0]  ScanData,
    input  logic        ScanEnd,
    output logic        ScanReady,
    output logic        OutValid,
    output logic [7:0]  OutData,
    input  logic        OutReady,
    output logic        Busy,
    output logic        Done
);

    state_t      state;
    logic [9:0]  byte_idx;
    logic        rom_wait;
    logic        three_q;
    logic [15:0] width_q;
    logic [15:0] height_q;
    logic [7:0]  samp_q;
    logic        end_pend;
    logic        eoi_queued;

    logic        free;
    logic [7:0]  fld_byte;
    logic        fld_rom;
    logic        fld_last;
    logic [7:0]  rom_byte;

    assign free      = !OutValid || OutReady;
    assign ScanReady = (state == ST_SCAN) && free;
    assign rom_byte  = (state == ST_DQT) ? DqtData : DhtData;

    aq_jpeg_hdr_field #(
        .DHT_BYTES (DHT_BYTES)
    ) u_field (
        .state    (state),
        .idx      (byte_idx),
        .three    (three_q),
        .width    (width_q),
        .height   (height_q),
        .samp     (samp_q),
        .hdr_byte (fld_byte),
        .rom_sel  (fld_rom),
        .seg_last (fld_last)
    );

    // Address follows byte_idx directly so ROM data is ready the cycle after the slot is reached.
    always_comb begin
        DqtAddr = '0;
        DhtAddr = '0;
        if (state == ST_DQT && fld_rom)
            DqtAddr = (byte_idx < 10'd70) ? {1'b0, 6'(byte_idx - 10'd5)}
                                          : {1'b1, 6'(byte_idx - 10'd70)};
        if (state == ST_DHT && fld_rom)
            DhtAddr = 9'(byte_idx - 10'd4);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            byte_idx   <= '0;
            rom_wait   <= 1'b0;
            three_q    <= 1'b0;
            width_q    <= '0;
            height_q   <= '0;
            samp_q     <= '0;
            end_pend   <= 1'b0;
            eoi_queued <= 1'b0;
            OutValid   <= 1'b0;
            OutData    <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (OutValid && OutReady)
                OutValid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        three_q  <= (CompNum != 3'd1);
                        width_q  <= Width;
                        height_q <= Height;
                        samp_q   <= (CompNum != 3'd1) ? {2'b00, SubSamplingW, 2'b00, SubSamplingH} : 8'h11;
                        byte_idx <= '0;
                        rom_wait <= 1'b0;
                        Busy     <= 1'b1;
                        state    <= ST_SOI;
                    end
                end
                ST_SOI, ST_DQT, ST_SOF, ST_DHT, ST_SOS: begin
                    if (fld_rom && !rom_wait) begin
                        rom_wait <= 1'b1;
                    end else if (free) begin
                        OutValid <= 1'b1;
                        OutData  <= fld_rom ? rom_byte : fld_byte;
                        rom_wait <= 1'b0;
                        if (fld_last) begin
                            state    <= next_segment(state);
                            byte_idx <= '0;
                        end else begin
                            byte_idx <= byte_idx + 10'd1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (ScanValid && ScanReady) begin
                        OutValid <= 1'b1;
                        OutData  <= ScanData;
                        end_pend <= ScanEnd;
                        if (ScanData == MK_PREFIX) begin
                            state <= ST_STUFF;
                        end else if (ScanEnd) begin
                            state    <= ST_EOI;
                            byte_idx <= '0;
                        end
                    end
                end
                ST_STUFF: begin
                    if (free) begin
                        OutValid <= 1'b1;
                        OutData  <= 8'h00;
                        byte_idx <= '0;
                        state    <= end_pend ? ST_EOI : ST_SCAN;
                    end
                end
                ST_EOI: begin
                    // Done waits for the D9 byte to actually leave the output register.
                    if (eoi_queued) begin
                        if (OutValid && OutReady) begin
                            eoi_queued <= 1'b0;
                            Done       <= 1'b1;
                            Busy       <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end else if (free) begin
                        OutValid <= 1'b1;
                        OutData  <= fld_byte;
                        if (fld_last)
                            eoi_queued <= 1'b1;
                        else
                            byte_idx <= byte_idx + 10'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
